// File: rtl/vx_tcu_drl_norm_round_pipe.sv
// vx_tcu_drl_norm_round_pipe
// Normalizes and rounds per-lane signed accumulator sums into FP32 results, or
// packs an integer result, through a 3-stage pipeline (S0 magnitude/LZC,
// S1 shift/round, S2 exponent fix/pack) sharing one valid/ready handshake.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   valid_in / ready_in    input beat handshake
//   tag_in, fmt_sel, rm    per-beat tag, result format (1 = INT), rounding mode
//   max_exp, acc_sig       per-lane max biased exponent and signed accumulator
//   hi_c, sig_signs        per-lane integer-mode upper-bit corrections
//   exceptions             per-lane {sign, class}: 00 normal, 01 Inf, 1x NaN
//   valid_out / ready_out  output beat handshake
//   tag_out, result        output tag and per-lane 32-bit result
//   fflags                 per-lane {NV, DZ, OF, UF, NX}
//
// Configuration: define TCU_NR_FFLAGS_EN to build the exception-flag logic;
// otherwise fflags is tied to zero and results are unaffected.
module vx_tcu_drl_norm_round_pipe #(
    parameter int N     = 5,
    parameter int W     = 53,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic [TAG_W-1:0]                 tag_in,
    input  logic                             fmt_sel,
    input  logic [2:0]                       rm,
    input  logic [LANES*8-1:0]               max_exp,
    input  logic [LANES*(W+$clog2(N)+1)-1:0] acc_sig,
    input  logic [LANES*7-1:0]               hi_c,
    input  logic [LANES*(N-1)-1:0]           sig_signs,
    input  logic [LANES*3-1:0]               exceptions,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [TAG_W-1:0]                 tag_out,
    output logic [LANES*32-1:0]              result,
    output logic [LANES*5-1:0]               fflags
);
    localparam int LG  = $clog2(N);
    localparam int AW  = W + LG + 1;
    localparam int MW  = W + LG - 1;
    localparam int LZW = $clog2(MW + 1);

    // Global enable: everything advances unless the output beat is stalled.
    logic en;
    assign en       = ~(valid_out & ~ready_out);
    assign ready_in = en;

    // Leading-zero count; an all-zero value yields MW.
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) lzc = LZW'(MW - 1 - i);
        end
    endfunction

    // ---------------- S0: magnitude, LZC, integer sum ----------------
    logic             s0_valid, s0_fmt;
    logic [TAG_W-1:0] s0_tag;
    logic [2:0]       s0_rm;
    logic             s0_sign  [LANES];
    logic [MW-1:0]    s0_mag   [LANES];
    logic [LZW-1:0]   s0_lz    [LANES];
    logic [7:0]       s0_mexp  [LANES];
    logic [2:0]       s0_exc   [LANES];
    logic [31:0]      s0_int   [LANES];

    logic             s0_sign_d [LANES];
    logic [MW-1:0]    s0_mag_d  [LANES];
    logic [31:0]      s0_int_d  [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic [AW-1:0]   a;
            logic signed [LG:0] top;
            logic [6:0]      hi;
            a    = acc_sig[l*AW +: AW];
            top  = a[AW-1:W];
            hi   = 7'(top) + hi_c[l*7 +: 7];
            for (int j = 0; j < N - 1; j++) begin
                hi = hi + {7{sig_signs[l*(N-1)+j]}};
            end
            s0_sign_d[l] = a[MW];
            s0_mag_d[l]  = a[MW] ? (~a[MW-1:0] + MW'(1)) : a[MW-1:0];
            s0_int_d[l]  = {hi, a[W-25 +: 25]};
        end
    end

    // ---------------- S1: normalize shift and round ----------------
    logic             s1_valid, s1_fmt;
    logic [TAG_W-1:0] s1_tag;
    logic [2:0]       s1_rm;
    logic             s1_sign [LANES];
    logic             s1_zero [LANES];
    logic signed [9:0] s1_exp [LANES];
    logic [22:0]      s1_frac [LANES];
    logic [2:0]       s1_exc  [LANES];
    logic [31:0]      s1_int  [LANES];

    logic             s1_zero_d [LANES];
    logic signed [9:0] s1_exp_d [LANES];
    logic [22:0]      s1_frac_d [LANES];
    logic             s1_gx_d   [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic [MW-1:0] sh;
            logic          g, r, st, up;
            logic [24:0]   sum;
            sh = s0_mag[l] << s0_lz[l];
            g  = sh[MW-25];
            r  = sh[MW-26];
            st = |sh[MW-27:0];
            unique case (s0_rm)
                3'd1:    up = 1'b0;
                3'd2:    up = s0_sign[l] & (g | r | st);
                3'd3:    up = ~s0_sign[l] & (g | r | st);
                3'd4:    up = g;
                default: up = g & (sh[MW-24] | r | st);
            endcase
            // Hidden bit included so a rounding carry shows up in sum[24].
            sum           = {1'b0, sh[MW-1 -: 24]} + 25'(up);
            s1_frac_d[l]  = sum[24] ? sum[23:1] : sum[22:0];
            s1_exp_d[l]   = {2'b00, s0_mexp[l]} + 10'(LG) - 10'(s0_lz[l]) + 10'(sum[24]);
            s1_zero_d[l]  = (s0_mag[l] == '0);
            s1_gx_d[l]    = g | r | st;
        end
    end

    // ---------------- S2: exponent range check and pack ----------------
    logic [LANES*32-1:0] result_d;

    always_comb begin
        result_d = '0;
        for (int l = 0; l < LANES; l++) begin
            logic s, inf;
            s = s1_sign[l];
            unique case (s1_rm)
                3'd1:    inf = 1'b0;
                3'd2:    inf = s;
                3'd3:    inf = ~s;
                default: inf = 1'b1;
            endcase
            if (s1_fmt)                       result_d[l*32 +: 32] = s1_int[l];
            else if (s1_exc[l][1:0] == 2'b01) result_d[l*32 +: 32] = {s1_exc[l][2], 8'hFF, 23'h0};
            else if (s1_exc[l][1])            result_d[l*32 +: 32] = {s1_exc[l][2], 8'hFF, 23'h400000};
            else if (s1_zero[l])              result_d[l*32 +: 32] = {s1_rm == 3'd2, 31'h0};
            else if (s1_exp[l] >= 10'sd255)
                result_d[l*32 +: 32] = inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
            else if (s1_exp[l] <= 10'sd0)     result_d[l*32 +: 32] = {s, 31'h0};
            else result_d[l*32 +: 32] = {s, s1_exp[l][7:0], s1_frac[l]};
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            valid_out <= 1'b0;
            tag_out   <= '0;
            result    <= '0;
        end else if (en) begin
            s0_valid  <= valid_in;
            s1_valid  <= s0_valid;
            valid_out <= s1_valid;
            tag_out   <= s1_tag;
            result    <= result_d;
        end
    end

    // Stage payload needs no reset; it is qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (en) begin
            s0_tag <= tag_in;
            s0_fmt <= fmt_sel;
            s0_rm  <= rm;
            s1_tag <= s0_tag;
            s1_fmt <= s0_fmt;
            s1_rm  <= s0_rm;
            for (int l = 0; l < LANES; l++) begin
                s0_sign[l] <= s0_sign_d[l];
                s0_mag[l]  <= s0_mag_d[l];
                s0_lz[l]   <= lzc(s0_mag_d[l]);
                s0_mexp[l] <= max_exp[l*8 +: 8];
                s0_exc[l]  <= exceptions[l*3 +: 3];
                s0_int[l]  <= s0_int_d[l];
                s1_sign[l] <= s0_sign[l];
                s1_zero[l] <= s1_zero_d[l];
                s1_exp[l]  <= s1_exp_d[l];
                s1_frac[l] <= s1_frac_d[l];
                s1_exc[l]  <= s0_exc[l];
                s1_int[l]  <= s0_int[l];
            end
        end
    end

`ifdef TCU_NR_FFLAGS_EN
    logic                s1_nx [LANES];
    logic [LANES*5-1:0]  fflags_d;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int l = 0; l < LANES; l++) s1_nx[l] <= s1_gx_d[l];
        end
    end

    // Flags only apply to finite, nonzero FP results.
    always_comb begin
        fflags_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!s1_fmt && s1_exc[l][1:0] == 2'b00 && !s1_zero[l]) begin
                if (s1_exp[l] >= 10'sd255)    fflags_d[l*5 +: 5] = 5'b00101;
                else if (s1_exp[l] <= 10'sd0) fflags_d[l*5 +: 5] = 5'b00011;
                else                          fflags_d[l*5 +: 5] = {4'b0, s1_nx[l]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  fflags <= '0;
        else if (en)   fflags <= fflags_d;
    end
`else
    assign fflags = '0;
`endif

endmodule
